// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cnn_pkg
// Description : Shared constants, scan FSM state encoding and the window
//               count helper used by the window scanner and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // Convolution kernel edge length; windows are KSIZE x KSIZE pixels.
    localparam int KSIZE = 3;

    // Scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Number of fully contained KSIZE x KSIZE windows in an img_w x img_h image.
    function automatic int win_count(input int img_w, input int img_h);
        return (img_w - KSIZE + 1) * (img_h - KSIZE + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_window_scan_if.sv
`default_nettype none
// ============================================================================
// Interface   : memory_window_scan_if
// Description : Bundles the pixel load port, scan control and window
//               handshake of memory_window_scan. The host side uses the
//               master modport, the scanner uses the slave modport.
//               MEMORY_WINDOW_READBACK_EN adds the raw readback port
//               (radd/rdata).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_window_scan_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    import cnn_pkg::*;

    // Pixel load port
    logic                          wen;
    logic [ADDR_W-1:0]             wadd;
    logic [DATA_W-1:0]             wdata;
    logic                          mem_full;

    // Scan control
    logic                          start;
    logic                          busy;
    logic                          done;

    // Window stream
    logic                          win_valid;
    logic                          win_ready;
    logic [KSIZE*KSIZE*DATA_W-1:0] win_data;
    logic [7:0]                    win_row;
    logic [7:0]                    win_col;

`ifdef MEMORY_WINDOW_READBACK_EN
    logic [ADDR_W-1:0]             radd;
    logic [DATA_W-1:0]             rdata;
`endif

    modport master (
        output wen, wadd, wdata, start, win_ready,
`ifdef MEMORY_WINDOW_READBACK_EN
        output radd,
        input  rdata,
`endif
        input  mem_full, busy, done, win_valid, win_data, win_row, win_col
    );

    modport slave (
        input  wen, wadd, wdata, start, win_ready,
`ifdef MEMORY_WINDOW_READBACK_EN
        input  radd,
        output rdata,
`endif
        output mem_full, busy, done, win_valid, win_data, win_row, win_col
    );

endinterface
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_addr_gen
// Description : Raster-order window coordinate generator. Tracks the current
//               top-left (row, col), wraps the column at the last valid
//               window position and flags the final window of the image.
//               row_nxt/col_nxt expose the coordinate that will be current
//               after this cycle so the caller can prefetch that window.
// Revision    : 1.0 - initial release
// ============================================================================
module window_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic [7:0] row_nxt,
    output logic [7:0] col_nxt,
    output logic       last
);

    localparam int               NUM_WIN  = win_count(IMG_W, IMG_H);
    localparam int               IDX_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam logic [7:0]       COL_MAX  = 8'(IMG_W - KSIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WIN - 1);

    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next coordinate: restart at (0,0) on clear, step raster order on advance.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        idx_d = idx_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
            idx_d = '0;
        end else if (advance) begin
            idx_d = idx_q + 1'b1;
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // Coordinate and window-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign row_nxt = row_d;
    assign col_nxt = col_d;
    assign last    = (idx_q == IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/memory_window_scan.sv
`default_nettype none
// ============================================================================
// Module      : memory_window_scan
// Description : Image buffer with a 3x3 sliding-window scanner. Pixels are
//               loaded row-major while idle; a start request then streams
//               every fully contained window in raster order over a
//               valid/ready handshake, each pixel offset by OFFSET_IN
//               (modulo 2**DATA_W). Window data is registered, so the next
//               window is fetched from its coordinate one cycle ahead.
//               Define MEMORY_WINDOW_READBACK_EN to add the raw combinational
//               readback port radd/rdata on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_window_scan
    import cnn_pkg::*;
#(
    parameter int        DATA_W    = 16,
    parameter int        IMG_W     = 28,
    parameter int        IMG_H     = 28,
    parameter int        ADDR_W    = 10,
    parameter int signed OFFSET_IN = 6
) (
    input  logic                clk,
    input  logic                rst,
    memory_window_scan_if.slave bus
);

    localparam int                MEM_DEPTH  = IMG_W * IMG_H;
    localparam int                NPIX       = KSIZE * KSIZE;
    localparam int                WIN_W      = NPIX * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [DATA_W-1:0] OFFSET_VAL = DATA_W'(OFFSET_IN);

    // Pixel storage; deliberately not reset so an image survives rst.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    scan_state_e       state_q, state_d;
    logic              mem_full_q, mem_full_d;
    logic [WIN_W-1:0]  win_data_q, win_data_d;
    logic [WIN_W-1:0]  win_next;

    logic              wr_en;
    logic              start_ok;
    logic              xfer;
    logic              advance;
    logic              load_win;
    logic              last_win;
    logic [7:0]        row, col, row_nxt, col_nxt;

    assign wr_en    = bus.wen && (state_q == ST_IDLE);
    assign start_ok = bus.start && mem_full_q && (state_q == ST_IDLE);
    assign xfer     = (state_q == ST_SCAN) && bus.win_ready;
    assign advance  = xfer && !last_win;
    assign load_win = start_ok || advance;

    window_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .advance (advance),
        .row     (row),
        .col     (col),
        .row_nxt (row_nxt),
        .col_nxt (col_nxt),
        .last    (last_win)
    );

    // Pixel store write port; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(bus.wadd) < MEM_DEPTH)) begin
            mem[bus.wadd] <= bus.wdata;
        end
    end

    // Image-loaded flag: set by the last pixel, cleared by rewriting pixel 0.
    always_comb begin
        mem_full_d = mem_full_q;
        if (wr_en) begin
            if (bus.wadd == LAST_ADDR) begin
                mem_full_d = 1'b1;
            end else if (bus.wadd == '0) begin
                mem_full_d = 1'b0;
            end
        end
    end

    // Gather the window at the upcoming coordinate and apply the zero-point offset.
    always_comb begin
        win_next = '0;
        for (int k = 0; k < NPIX; k++) begin
            win_next[k*DATA_W +: DATA_W] =
                mem[ADDR_W'((int'(row_nxt) + k / KSIZE) * IMG_W + int'(col_nxt) + k % KSIZE)]
                + OFFSET_VAL;
        end
    end

    // Window register only reloads when a new window becomes current.
    always_comb begin
        win_data_d = win_data_q;
        if (load_win) begin
            win_data_d = win_next;
        end
    end

    // Scan FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok)         state_d = ST_SCAN;
            ST_SCAN: if (xfer && last_win) state_d = ST_DONE;
            ST_DONE:                       state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // State, load flag and window registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_full_q <= 1'b0;
            win_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_full_q <= mem_full_d;
            win_data_q <= win_data_d;
        end
    end

    assign bus.mem_full  = mem_full_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.win_valid = (state_q == ST_SCAN);
    assign bus.win_data  = win_data_q;
    assign bus.win_row   = row;
    assign bus.win_col   = col;

`ifdef MEMORY_WINDOW_READBACK_EN
    assign bus.rdata = mem[bus.radd];
`endif

endmodule
`default_nettype wire
